// File: rtl/mult_div_unit_pkg.sv
// Shared definitions for the HI/LO multiply-divide unit: SPECIAL-opcode funct codes,
// default latencies and the decoded-instruction record.
package mult_div_unit_pkg;

  localparam logic [5:0] OP_SPECIAL = 6'b000000;

  localparam logic [5:0] FN_MULT  = 6'b011000;
  localparam logic [5:0] FN_MULTU = 6'b011001;
  localparam logic [5:0] FN_DIV   = 6'b011010;
  localparam logic [5:0] FN_DIVU  = 6'b011011;
  localparam logic [5:0] FN_MFHI  = 6'b010000;
  localparam logic [5:0] FN_MFLO  = 6'b010010;
  localparam logic [5:0] FN_MTHI  = 6'b010001;
  localparam logic [5:0] FN_MTLO  = 6'b010011;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

  typedef enum logic {
    MD_IDLE,
    MD_RUN
  } md_state_e;

  typedef struct packed {
    logic is_mult;
    logic is_multu;
    logic is_div;
    logic is_divu;
    logic is_mfhi;
    logic is_mflo;
    logic is_mthi;
    logic is_mtlo;
    logic is_md;
  } md_dec_t;

endpackage

// File: rtl/mult_div_unit_if.sv
// Pipeline-side bundle of the multiply-divide unit: D/EX instructions and forwarded
// operands in, HI/LO state, EX result and stall request out.
interface mult_div_unit_if;
  logic [31:0] ID_Instr_o;
  logic [31:0] EX_Instr_o;
  logic [31:0] EX_RD1_o_forward;
  logic [31:0] EX_RD2_o_forward;
  logic        E_Start;
  logic        E_Busy;
  logic [31:0] HI;
  logic [31:0] LO;
  logic [31:0] E_MDout;
  logic        MD_stall;

  modport master (
    output ID_Instr_o, EX_Instr_o, EX_RD1_o_forward, EX_RD2_o_forward,
    input  E_Start, E_Busy, HI, LO, E_MDout, MD_stall
  );

  modport slave (
    input  ID_Instr_o, EX_Instr_o, EX_RD1_o_forward, EX_RD2_o_forward,
    output E_Start, E_Busy, HI, LO, E_MDout, MD_stall
  );
endinterface

// File: rtl/mult_div_unit_md_decode.sv
// Classifies one instruction word into the HI/LO operations; used for both the D and
// EX stage instructions.
module md_decode
  import mult_div_unit_pkg::*;
(
  input  logic [31:0] instr,
  output md_dec_t     dec
);

  // Register fields play no part in classification.
  logic unused_fields;
  assign unused_fields = ^instr[25:6];

  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    dec = '0;
    if (instr[31:26] == OP_SPECIAL) begin
      case (instr[5:0])
        FN_MULT:  dec.is_mult  = 1'b1;
        FN_MULTU: dec.is_multu = 1'b1;
        FN_DIV:   dec.is_div   = 1'b1;
        FN_DIVU:  dec.is_divu  = 1'b1;
        FN_MFHI:  dec.is_mfhi  = 1'b1;
        FN_MFLO:  dec.is_mflo  = 1'b1;
        FN_MTHI:  dec.is_mthi  = 1'b1;
        FN_MTLO:  dec.is_mtlo  = 1'b1;
        default:  ;
      endcase
    end
    dec.is_md = dec.is_mult | dec.is_multu | dec.is_div | dec.is_divu |
                dec.is_mfhi | dec.is_mflo | dec.is_mthi | dec.is_mtlo;
  end

endmodule

// File: rtl/mult_div_unit.sv
// HI/LO multiply-divide unit of the EX stage: fixed-latency mult/div, mthi/mtlo/mfhi/mflo
// and the D-stage stall request while an operation is pending.
module mult_div_unit
  import mult_div_unit_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input logic            clk,
  input logic            reset,
  mult_div_unit_if.slave md
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  md_dec_t id_dec;
  md_dec_t ex_dec;

  md_decode u_id_decode (.instr(md.ID_Instr_o), .dec(id_dec));
  md_decode u_ex_decode (.instr(md.EX_Instr_o), .dec(ex_dec));

  md_state_e        state;
  logic [CNT_W-1:0] cnt;
  logic             busy;
  logic [31:0]      hi_q;
  logic [31:0]      lo_q;
  logic [63:0]      pend;
  logic             pend_wr;

  logic [31:0] a;
  logic [31:0] b;
  logic        is_mul_op;
  logic        is_div_op;
  logic        start;
  logic        div_zero;

  assign a         = md.EX_RD1_o_forward;
  assign b         = md.EX_RD2_o_forward;
  assign is_mul_op = ex_dec.is_mult | ex_dec.is_multu;
  assign is_div_op = ex_dec.is_div | ex_dec.is_divu;
  assign start     = (is_mul_op | is_div_op) & ~busy;
  assign div_zero  = (b == 32'd0);

  logic signed [63:0] prod_s;
  logic        [63:0] prod_u;
  logic signed [32:0] s_dividend;
  logic signed [32:0] s_divisor;
  logic signed [32:0] s_quot;
  logic signed [32:0] s_rem;
  logic        [31:0] u_divisor;
  logic        [31:0] u_quot;
  logic        [31:0] u_rem;
  logic        [63:0] result;

  assign prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
  assign prod_u = {32'd0, a} * {32'd0, b};

  // 33-bit signed divide keeps -2^31 / -1 free of overflow; a zero divisor is
  // replaced by 1 because its result is never committed.
  assign s_dividend = {a[31], a};
  assign s_divisor  = div_zero ? 33'sd1 : {b[31], b};
  assign s_quot     = s_dividend / s_divisor;
  assign s_rem      = s_dividend % s_divisor;
  assign u_divisor  = div_zero ? 32'd1 : b;
  assign u_quot     = a / u_divisor;
  assign u_rem      = a % u_divisor;

  always_comb begin
    result = '0;
    if (ex_dec.is_mult)       result = prod_s;
    else if (ex_dec.is_multu) result = prod_u;
    else if (ex_dec.is_div)   result = {s_rem[31:0], s_quot[31:0]};
    else if (ex_dec.is_divu)  result = {u_rem, u_quot};
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      state   <= MD_IDLE;
      cnt     <= '0;
      busy    <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      pend    <= '0;
      pend_wr <= 1'b0;
    end else begin
      case (state)
        MD_IDLE: begin
          if (start) begin
            pend    <= result;
            pend_wr <= ~(is_div_op & div_zero);
            cnt     <= is_mul_op ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
            busy    <= 1'b1;
            state   <= MD_RUN;
          end else begin
            if (ex_dec.is_mthi) hi_q <= a;
            if (ex_dec.is_mtlo) lo_q <= a;
          end
        end
        MD_RUN: begin
          cnt <= cnt - 1'b1;
          if (cnt == CNT_W'(1)) begin
            if (pend_wr) begin
              hi_q <= pend[63:32];
              lo_q <= pend[31:0];
            end
            busy  <= 1'b0;
            state <= MD_IDLE;
          end
        end
      endcase
    end
  end

  assign md.E_Start  = start;
  assign md.E_Busy   = busy;
  assign md.HI       = hi_q;
  assign md.LO       = lo_q;
  assign md.E_MDout  = ex_dec.is_mfhi ? hi_q : (ex_dec.is_mflo ? lo_q : 32'd0);
  assign md.MD_stall = (start | busy) & id_dec.is_md;

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
HI/LO multiply-divide unit in the EX stage of the 5-stage MIPS pipeline. It consumes the forwarded EX operands (EX_RD1_o_forward, EX_RD2_o_forward) and the EX instruction. It executes mult/multu/div/divu with fixed multi-cycle latency, services mthi/mtlo/mfhi/mflo, and raises a stall request for the D stage while an operation is pending.

Parameters:
MULT_CYCLES, 5, busy cycles for mult/multu (>=1)
DIV_CYCLES, 10, busy cycles for div/divu (>=1)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high; clears all state
ID_Instr_o  input  32  instruction in D stage (stall decode)
EX_Instr_o  input  32  instruction in EX stage (operation decode)
EX_RD1_o_forward  input  32  forwarded rs value (operand A / mthi/mtlo data)
EX_RD2_o_forward  input  32  forwarded rt value (operand B)
E_Start  output  1  combinational: EX holds mult/multu/div/divu and E_Busy==0
E_Busy  output  1  registered: operation in flight
HI  output  32  architectural HI register
LO  output  32  architectural LO register
E_MDout  output  32  mfhi -> HI, mflo -> LO, else 0 (combinational, into EX result mux)
MD_stall  output  1  (E_Start | E_Busy) & ID instr in {mult,multu,div,divu,mfhi,mflo,mthi,mtlo}

Behaviour:
- Decode: op=31:26, func=5:0; mult 011000, multu 011001, div 011010, divu 011011, mfhi 010000, mflo 010010, mthi 010001, mtlo 010011, all op=000000.
- Reset (sync, active-high): HI=0, LO=0, E_Busy=0, counter=0, pending result=0. Reset overrides everything, including mid-operation: in-flight result discarded, HI/LO=0.
- States: IDLE (E_Busy=0), RUN (E_Busy=1). Counter width ceil(log2(max(MULT_CYCLES,DIV_CYCLES)+1)).
- IDLE & E_Start at edge: compute 64-bit result from current operands and latch it into pending {hi,lo}. Load counter with MULT_CYCLES or DIV_CYCLES. E_Busy<=1.
- RUN: counter decrements each edge. On the edge where counter==1: HI/LO <= pending, E_Busy<=0, back to IDLE.
- Latency: start in cycle t -> E_Busy high in cycles t+1..t+N. New HI/LO are visible from cycle t+N+1. An mfhi/mflo in EX at t+N+1 reads the new value.
- mult: signed 32x32 -> 64, HI=[63:32], LO=[31:0]. multu: unsigned.
- div: signed, LO=quotient truncated toward zero, HI=remainder with dividend's sign. divu: unsigned.
- Divide by zero: RUN sequence still takes DIV_CYCLES; at completion HI/LO keep their pre-op values. No exception.
- mthi/mtlo in EX with E_Busy==0: HI (resp. LO) <= EX_RD1_o_forward at edge.
- mthi/mtlo in EX with E_Busy==1: write ignored. MD_stall makes this unreachable; the bench asserts it never happens.
- mult-class in EX while E_Busy==1: E_Start=0 and the instruction is ignored. Also unreachable under MD_stall; asserted.
- E_MDout returns HI/LO as currently registered. No bypass of pending values.
- MD_stall is purely combinational and lives in this block. The hazard unit ORs it into the D-stage stall and EX-bubble insertion.
- Bubble in EX (all-zero instr = sll $0) performs no MD action.

Decomposition:
- Shared package: funct constants (MULT, MULTU, DIV, DIVU, MFHI, MFLO, MTHI, MTLO), SPECIAL opcode 000000, MULT_CYCLES/DIV_CYCLES defaults.
- Optional sub-module md_decode: instruction -> {is_mult, is_multu, is_div, is_divu, is_mfhi, is_mflo, is_mthi, is_mtlo, is_md}. Instantiated twice (ID and EX).

Test Plan:
- mult with A=0xFFFFFFFD (-3), B=5 -> E_Busy high exactly 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFF1; mflo next cycle gives E_MDout=0xFFFFFFF1.
- multu A=0xFFFFFFFF, B=2 -> HI=0x00000001, LO=0xFFFFFFFE after 5 busy cycles.
- div A=0xFFFFFFF9 (-7), B=2 -> E_Busy 10 cycles, LO=0xFFFFFFFD, HI=0xFFFFFFFF. divu same operands -> LO=0x7FFFFFFC, HI=0x00000001.
- mthi 0x12345678, mtlo 0x9ABCDEF0, then divu A=7, B=0 -> after 10 busy cycles HI=0x12345678, LO=0x9ABCDEF0 unchanged.
- mult in EX with mfhi in ID -> MD_stall=1 on the start cycle and all 5 busy cycles, 0 in the cycle after E_Busy falls. addu in ID during busy -> MD_stall=0.
- div started, reset asserted on 4th busy cycle -> next edge E_Busy=0, HI=LO=0, and no late HI/LO update in later cycles.
